// File: rtl/fetch_unit_pkg.sv
// Shared fetch-side definitions: FSM encodings, reset PC default,
// buffer entry layout and the memory command codes used on this bus.
package fetch_unit_pkg;

   localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

   localparam logic [1:0] MEM_CMD_NONE  = 2'd0;
   localparam logic [1:0] MEM_CMD_READ  = 2'd1;
   localparam logic [1:0] MEM_CMD_WRITE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] data;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc,data} entries between fetch and decode.
// Flush dominates push/pop; a push into a full buffer needs a same-cycle pop.
module fetch_buffer
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  push_entry,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   localparam int PW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          do_pop;

   assign full   = (count == CW'(DEPTH));
   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers/count define validity.
   always_ff @(posedge clk) begin
      if (!reset && !flush && push) mem[wr_ptr] <= push_entry;
   end

   overflow_chk: assert property (@(posedge clk) disable iff (reset || flush)
                                  !(push && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding request to memory_system,
// redirect/flush handling, and a small buffer presenting words to decode.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] fetch_addr,
   output logic        fetch_request,
   input  logic        fetch_data_valid,
   input  logic [31:0] request_data,
   input  logic        mem_stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int CW = $clog2(BUF_DEPTH + 1);

   fetch_state_e  state;
   fetch_state_e  state_nxt;
   logic [31:0]   pc;
   logic [31:0]   pc_nxt;
   logic [31:0]   req_addr;
   logic [CW-1:0] count;
   logic          pop;
   logic          push;
   logic          flush;
   logic          has_free;
   logic          issue;
   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic          unused_stall;

   assign unused_stall = mem_stall;

   assign inst_valid = !reset && (count != '0);
   assign inst_data  = head.data;
   assign inst_pc    = head.pc;
   assign pop        = inst_valid && inst_ready;
   assign flush      = redirect_valid && !reset;
   assign push_entry = '{pc: req_addr, data: request_data};

   // free = BUF_DEPTH - count + pop; only its sign matters for issuing.
   assign has_free = (int'(count) < BUF_DEPTH) || pop;

   always_comb begin
      state_nxt     = state;
      pc_nxt        = pc;
      push          = 1'b0;
      issue         = 1'b0;
      fetch_request = 1'b0;
      fetch_addr    = pc;
      case (state)
         ST_IDLE: begin
            if (!redirect_valid && has_free) begin
               fetch_request = 1'b1;
               issue         = 1'b1;
               state_nxt     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            fetch_request = 1'b1;
            fetch_addr    = req_addr;
            if (fetch_data_valid) begin
               state_nxt = ST_IDLE;
               if (!redirect_valid) begin
                  push   = 1'b1;
                  pc_nxt = req_addr + 32'd4;
               end
            end else if (redirect_valid) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            fetch_request = 1'b1;
            fetch_addr    = req_addr;
            if (fetch_data_valid) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (redirect_valid) pc_nxt = align_word(redirect_pc);
      // Reset drops any in-flight request at once and ignores its response.
      if (reset) begin
         fetch_request = 1'b0;
         fetch_addr    = RESET_PC;
         push          = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         state <= state_nxt;
         pc    <= pc_nxt;
         if (issue) req_addr <= pc;
      end
   end

   fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .push_entry (push_entry),
      .count      (count),
      .head       (head)
   );

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, giving the instruction buffer entries; legal values are 2 and 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port fetch_addr, output, 32 bits: word-aligned fetch address to memory_system.
REQ-006 SHALL have port fetch_request, output, 1 bit: level request; held until fetch_data_valid.
REQ-007 SHALL have port fetch_data_valid, input, 1 bit: the fetch completes this cycle.
REQ-008 SHALL have port request_data, input, 32 bits: fetched word, qualified by fetch_data_valid.
REQ-009 SHALL have port mem_stall, input, 1 bit: memory_system stall, used for observation only with no functional effect.
REQ-010 SHALL have port redirect_valid, input, 1 bit: flush the unit and restart at redirect_pc.
REQ-011 SHALL have port redirect_pc, input, 32 bits: new PC; bits [1:0] are ignored and treated as 0.
REQ-012 SHALL have port inst_valid, output, 1 bit: a buffer-head instruction is presented to decode.
REQ-013 SHALL have port inst_data, output, 32 bits: the head instruction word.
REQ-014 SHALL have port inst_pc, output, 32 bits: the head instruction address.
REQ-015 SHALL have port inst_ready, input, 1 bit: decode accepts the head when inst_valid is also high.

Function
REQ-016 SHALL implement three states:
- IDLE: no request outstanding.
- WAIT: request outstanding, result is kept.
- DRAIN: request outstanding, result is discarded.
REQ-017 SHALL transition IDLE->WAIT when free > 0, where free = BUF_DEPTH - count + pop and pop = inst_valid && inst_ready; fetch_request SHALL be asserted combinationally in that same cycle with fetch_addr = pc.
REQ-018 SHALL keep fetch_request high and fetch_addr stable in WAIT and DRAIN until fetch_data_valid; a request is never withdrawn early.
REQ-019 SHALL, on fetch_data_valid in WAIT without redirect, push {pc, request_data}, set pc <= pc+4 (32-bit wrap from 32'hFFFF_FFFC to 0), and return to IDLE.
REQ-020 SHALL, on fetch_data_valid in DRAIN, discard request_data, leave pc unchanged, and return to IDLE.
REQ-021 SHALL, on redirect_valid, empty the buffer, set pc <= {redirect_pc[31:2], 2'b00}, and handle the outstanding request as follows:
- WAIT without fetch_data_valid: go to DRAIN.
- WAIT with fetch_data_valid in the same cycle: discard the data and go to IDLE.
- IDLE or DRAIN: keep or enter IDLE/DRAIN unchanged.
REQ-022 SHALL block new requests in the redirect cycle; requests resume the next cycle in IDLE.
REQ-023 SHALL give 1 cycle latency from fetch_data_valid to inst_valid, since the buffer output is registered.
REQ-024 SHALL accept push and pop in the same cycle when the buffer is full; count is unchanged and order is FIFO.
REQ-025 SHALL make a pop coincident with redirect_valid take effect; the flush wins and the buffer is empty afterwards.
REQ-026 SHALL never push when full without a same-cycle pop; REQ-017 guarantees this, and an overflow assertion is required.
REQ-027 SHALL drive inst_data and inst_pc as don't-care when inst_valid is low.

Reset
REQ-028 SHALL, in a reset cycle, set state=IDLE, pc=RESET_PC, buffer count=0, fetch_request=0, inst_valid=0, and fetch_addr=RESET_PC.
REQ-029 SHALL, if reset occurs mid-request, drop the request immediately and ignore any fetch_data_valid seen during reset.
REQ-030 SHALL assert the first fetch_request in the first cycle with reset low.

Structure
REQ-031 SHALL place the state encodings and the RESET_PC default in the shared defines file alongside the `MEM_CMD_* constants.
REQ-032 SHALL implement the buffer as the sub-module fetch_buffer, a parameterised synchronous FIFO of 64-bit {pc,data} entries with push, pop, flush, count, and head outputs.
REQ-033 SHALL be instantiated directly upstream of memory_system, connected to its fetch_* ports.

Verification
REQ-034 SHALL cover reset release with a memory latency of 2 cycles -> fetch_addr 0x0, 0x4, 0x8 in order; inst_pc 0x0 with inst_valid 1 cycle after the first fetch_data_valid.
REQ-035 SHALL cover inst_ready held low -> exactly BUF_DEPTH words buffered, then fetch_request stays low; raising inst_ready resumes fetching in the same cycle.
REQ-036 SHALL cover redirect_valid to 0x1003 while WAIT -> response discarded, next fetch_addr=0x1000, first inst_pc=0x1000.
REQ-037 SHALL cover redirect coincident with fetch_data_valid -> the word is not delivered, no DRAIN, next request at redirect_pc.
REQ-038 SHALL cover pc=32'hFFFF_FFFC fetched -> next fetch_addr=0x0.
REQ-039 SHALL cover reset asserted during WAIT, with fetch_data_valid arriving in the reset cycle -> inst_valid stays 0 and the first fetch after reset is at RESET_PC.
